// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, response status encoding, FSM states and the start-position lookup.
package chess_pkg;
  localparam int COLOR_BIT = 3;
  localparam logic [2:0] NONE = 3'd0, PAWN = 3'd1, ROOK = 3'd2, KNIGHT = 3'd3;
  localparam logic [2:0] BISHOP = 3'd4, QUEEN = 3'd5, KING = 3'd6;
  typedef enum logic [2:0] {ST_OK = 3'd0, ST_EMPTY = 3'd1, ST_OWNER = 3'd2, ST_OWN_TGT = 3'd3, ST_OVER = 3'd4} status_t;
  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RESP} state_t;
  localparam logic [23:0] BACK_RANK = {ROOK, KNIGHT, BISHOP, KING, QUEEN, BISHOP, KNIGHT, ROOK};
  function automatic logic [3:0] start_piece(input logic [5:0] sq);
    logic [2:0] kind;
    kind = BACK_RANK[sq[2:0]*3 +: 3];
    return sq[5:3] == 3'd0 ? {1'b0, kind} :
           sq[5:3] == 3'd1 ? {1'b0, PAWN} :
           sq[5:3] == 3'd6 ? {1'b1, PAWN} :
           sq[5:3] == 3'd7 ? {1'b1, kind} : 4'h0;
  endfunction
endpackage

// File: rtl/board_regs.sv
// board_regs: 64x4 board register file, reset to the start position, check/read ports and a to/from move write.
module board_regs
  import chess_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [5:0] wr_from,
  input  logic [5:0] wr_to,
  input  logic [3:0] wr_data,
  input  logic [5:0] chk_from,
  input  logic [5:0] chk_to,
  output logic [3:0] chk_src,
  output logic [3:0] chk_dst,
  input  logic [5:0] rd_addr,
  output logic [3:0] rd_data
);
  logic [3:0] cells_q [64];
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) cells_q[i] <= start_piece(6'(i));
    end else if (we) begin
      cells_q[wr_from] <= 4'h0;
      cells_q[wr_to]   <= wr_data;
    end
  end
  assign chk_src = cells_q[chk_from];
  assign chk_dst = cells_q[chk_to];
  assign rd_data = cells_q[rd_addr];
endmodule

// File: rtl/move_executor.sv
// move_executor: validates and commits chess moves on the board; AUTO_PROMOTE_EN turns last-rank pawns into queens.
module move_executor
  import chess_pkg::*;
#(
  parameter int PLY_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mv_valid,
  output logic             mv_ready,
  input  logic [5:0]       mv_from,
  input  logic [5:0]       mv_to,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [3:0]       rsp_captured,
  output logic             turn,
  output logic             game_over,
  output logic [PLY_W-1:0] ply,
  input  logic [5:0]       rd_addr,
  output logic [3:0]       rd_data
);
  state_t           state_q;
  status_t          rsp_status_q, chk_status;
  logic             mv_ready_q, rsp_valid_q, turn_q, game_over_q;
  logic [3:0]       rsp_captured_q, src, dst, place_d;
  logic [5:0]       from_q, to_q;
  logic [PLY_W-1:0] ply_q;
  board_regs u_board (
    .clock(clock), .reset(reset), .we(state_q == COMMIT),
    .wr_from(from_q), .wr_to(to_q), .wr_data(place_d),
    .chk_from(from_q), .chk_to(to_q), .chk_src(src), .chk_dst(dst),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
`ifdef AUTO_PROMOTE_EN
  assign place_d = (src[2:0] == PAWN && to_q[5:3] == {3{~src[COLOR_BIT]}}) ? {src[COLOR_BIT], QUEEN} : src;
`else
  assign place_d = src;
`endif
  always_comb begin
    chk_status = game_over_q ? ST_OVER :
                 src[2:0] == NONE ? ST_EMPTY :
                 src[COLOR_BIT] != turn_q ? ST_OWNER :
                 (from_q == to_q || (dst[2:0] != NONE && dst[COLOR_BIT] == turn_q)) ? ST_OWN_TGT : ST_OK;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      mv_ready_q     <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_status_q   <= ST_OK;
      rsp_captured_q <= 4'h0;
      turn_q         <= 1'b0;
      game_over_q    <= 1'b0;
      ply_q          <= '0;
      from_q         <= '0;
      to_q           <= '0;
    end else begin
      case (state_q)
        IDLE: if (mv_valid) begin
          from_q     <= mv_from;
          to_q       <= mv_to;
          mv_ready_q <= 1'b0;
          state_q    <= CHECK;
        end
        CHECK: if (chk_status != ST_OK) begin
          rsp_status_q   <= chk_status;
          rsp_captured_q <= 4'h0;
          rsp_valid_q    <= 1'b1;
          state_q        <= RESP;
        end else begin
          state_q <= COMMIT;
        end
        COMMIT: begin
          rsp_status_q   <= ST_OK;
          rsp_captured_q <= dst;
          turn_q         <= ~turn_q;
          ply_q          <= &ply_q ? ply_q : ply_q + PLY_W'(1);
          game_over_q    <= game_over_q | (dst[2:0] == KING);
          rsp_valid_q    <= 1'b1;
          state_q        <= RESP;
        end
        default: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          mv_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign mv_ready     = mv_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_captured = rsp_captured_q;
  assign turn         = turn_q;
  assign game_over    = game_over_q;
  assign ply          = ply_q;
endmodule

// File: tb/tb_move_executor.sv
// tb_move_executor: directed moves with an expected-response queue checked when the executor answers.
module tb_move_executor;
  logic       clock = 1'b0, reset = 1'b1, mv_valid = 1'b0, rsp_ready = 1'b1;
  logic [5:0] mv_from = '0, mv_to = '0, rd_addr = '0;
  logic       mv_ready, rsp_valid, turn, game_over;
  logic [2:0] rsp_status;
  logic [3:0] rsp_captured, rd_data;
  logic [9:0] ply;
  int total = 0, bad = 0;
  typedef struct {logic [2:0] st; logic [3:0] cap;} rsp_t;
  rsp_t sb[$];
  localparam logic [2:0] BR [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd3, 3'd2};
  move_executor #(.PLY_W(10)) dut (
    .clock(clock), .reset(reset), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_from(mv_from), .mv_to(mv_to), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_captured(rsp_captured), .turn(turn),
    .game_over(game_over), .ply(ply), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic peek(input logic [5:0] sq, input logic [3:0] exp, input string tag);
    rd_addr = sq;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask
  task automatic do_reset();
    reset = 1'b1; mv_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask
  task automatic do_move(input logic [5:0] f, input logic [5:0] t, input logic [2:0] st,
                         input logic [3:0] cap, input int lat, input int hold);
    rsp_t e;
    int k;
    sb.push_back('{st, cap});
    rsp_ready = (hold == 0);
    @(negedge clock);
    check("ready_before", 32'(mv_ready), 32'd1);
    mv_valid = 1'b1; mv_from = f; mv_to = t;
    @(posedge clock);
    #1 mv_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 8) begin
      @(posedge clock); #1; k++;
    end
    check("latency", 32'(k), 32'(lat));
    e = sb.pop_front();
    check("status", 32'(rsp_status), 32'(e.st));
    check("captured", 32'(rsp_captured), 32'(e.cap));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_status", 32'(rsp_status), 32'(e.st));
      check("hold_ready", 32'(mv_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    check("ready_after", 32'(mv_ready), 32'd1);
    check("valid_after", 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    do_reset();
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_ply", 32'(ply), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_mv_ready", 32'(mv_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_status", 32'(rsp_status), 32'd0);
    check("rst_captured", 32'(rsp_captured), 32'd0);
    for (int s = 0; s < 64; s++) begin
      logic [3:0] exp;
      exp = (s / 8 == 0) ? {1'b0, BR[s % 8]} : (s / 8 == 1) ? 4'h1 :
            (s / 8 == 6) ? 4'h9 : (s / 8 == 7) ? {1'b1, BR[s % 8]} : 4'h0;
      peek(6'(s), exp, "start_sq");
    end
    peek(6'd4, 4'h6, "start_e1");
    peek(6'd60, 4'hE, "start_e8");
    peek(6'd20, 4'h0, "start_e3");
    do_move(6'd12, 6'd28, 3'd0, 4'h0, 2, 0);
    peek(6'd28, 4'h1, "e4_pawn");
    peek(6'd12, 4'h0, "e2_empty");
    check("e4_turn", 32'(turn), 32'd1);
    check("e4_ply", 32'(ply), 32'd1);
    do_reset();
    do_move(6'd20, 6'd28, 3'd1, 4'h0, 1, 0);
    do_move(6'd52, 6'd44, 3'd2, 4'h0, 1, 0);
    do_move(6'd0, 6'd1, 3'd3, 4'h0, 1, 0);
    do_move(6'd0, 6'd0, 3'd3, 4'h0, 1, 0);
    peek(6'd0, 4'h2, "rej_a1");
    peek(6'd1, 4'h3, "rej_b1");
    peek(6'd52, 4'h9, "rej_e7");
    peek(6'd44, 4'h0, "rej_e6");
    check("rej_turn", 32'(turn), 32'd0);
    check("rej_ply", 32'(ply), 32'd0);
    do_reset();
    do_move(6'd3, 6'd60, 3'd0, 4'hE, 2, 0);
    check("kcap_over", 32'(game_over), 32'd1);
    peek(6'd60, 4'h5, "kcap_queen");
    do_move(6'd52, 6'd44, 3'd4, 4'h0, 1, 0);
    peek(6'd52, 4'h9, "over_e7");
    peek(6'd44, 4'h0, "over_e6");
    check("over_turn", 32'(turn), 32'd1);
    check("over_ply", 32'(ply), 32'd1);
    do_reset();
    do_move(6'd8, 6'd56, 3'd0, 4'hA, 2, 0);
`ifdef AUTO_PROMOTE_EN
    peek(6'd56, 4'h5, "promo_a8");
`else
    peek(6'd56, 4'h1, "promo_a8");
`endif
    do_move(6'd51, 6'd43, 3'd0, 4'h0, 2, 5);
    check("stall_ply", 32'(ply), 32'd2);
    do_reset();
    @(negedge clock);
    mv_valid = 1'b1; mv_from = 6'd12; mv_to = 6'd28;
    @(posedge clock);
    #1 mv_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("rchk_ready", 32'(mv_ready), 32'd1);
    repeat (4) @(posedge clock);
    #1;
    check("rchk_valid", 32'(rsp_valid), 32'd0);
    check("rchk_turn", 32'(turn), 32'd0);
    peek(6'd12, 4'h1, "rchk_e2");
    peek(6'd28, 4'h0, "rchk_e4");
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
